// File: rtl/keypad_pkg.sv
// Shared types and defaults for the keypad debounce and event-queue stage.
package keypad_pkg;

    localparam int KEYCODE_W          = 4;
    localparam int KD_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
    localparam int KD_FIFO_DEPTH      = 4;

    typedef enum logic [1:0] {
        KD_IDLE         = 2'd0,
        KD_PRESS_WAIT   = 2'd1,
        KD_HELD         = 2'd2,
        KD_RELEASE_WAIT = 2'd3
    } kd_state_t;

endpackage

// File: rtl/keypad_event_fifo.sv
// Small synchronous key-event queue. The pointers carry one extra wrap bit,
// so full and empty can be told apart without a separate count.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = KD_FIFO_DEPTH,
    parameter int WIDTH = KEYCODE_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    // A push into a full queue only fits if the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces the keypad scanner's raw level outputs and queues one event per
// accepted press.
//
//   state           | meaning
//   ----------------+--------------------------------------------------
//   KD_IDLE         | no key down
//   KD_PRESS_WAIT   | key seen, waiting for a stable code for the window
//   KD_HELD         | press accepted, key down
//   KD_RELEASE_WAIT | key seen released, waiting for the release window
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KD_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH      = KD_FIFO_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [KEYCODE_W-1:0] keycode,
    input  logic                 keypressed,
    output logic                 key_valid,
    output logic [KEYCODE_W-1:0] key_data,
    input  logic                 key_ready,
    output logic                 key_held,
    output logic [KEYCODE_W-1:0] held_code,
    output logic                 overflow
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                 sync_pressed;
    logic                 s_pressed;
    logic [KEYCODE_W-1:0] sync_code;
    logic [KEYCODE_W-1:0] s_code;

    kd_state_t            state;
    kd_state_t            state_nxt;
    logic [KEYCODE_W-1:0] cand;
    logic [KEYCODE_W-1:0] cand_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;

    logic                 push_req;
    logic                 pop_req;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Two-flop synchronisers; the code bus is synced bit-wise because a torn
    // code only restarts the debounce window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_pressed <= 1'b0;
            s_pressed    <= 1'b0;
            sync_code    <= '0;
            s_code       <= '0;
        end else begin
            sync_pressed <= keypressed;
            s_pressed    <= sync_pressed;
            sync_code    <= keycode;
            s_code       <= sync_code;
        end
    end

    // FSM state register together with the candidate code and window counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= KD_IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; every state entry that starts a window clears the counter.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        case (state)
            KD_IDLE: begin
                if (s_pressed) begin
                    cand_nxt  = s_code;
                    cnt_nxt   = '0;
                    state_nxt = KD_PRESS_WAIT;
                end
            end
            KD_PRESS_WAIT: begin
                if (!s_pressed) begin
                    state_nxt = KD_IDLE;
                end else if (s_code != cand) begin
                    cand_nxt = s_code;
                    cnt_nxt  = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = KD_HELD;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            KD_HELD: begin
                // The scanner freezes while a key is down, so code changes are ignored.
                if (!s_pressed) begin
                    cnt_nxt   = '0;
                    state_nxt = KD_RELEASE_WAIT;
                end
            end
            KD_RELEASE_WAIT: begin
                if (s_pressed) begin
                    state_nxt = KD_HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = KD_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = KD_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register; the push fires on the
    // PRESS_WAIT -> HELD transition.
    always_comb begin
        key_held  = 1'b0;
        held_code = '0;
        push_req  = 1'b0;
        case (state)
            KD_PRESS_WAIT: begin
                push_req = s_pressed && (s_code == cand) && (cnt == CNT_LAST);
            end
            KD_HELD, KD_RELEASE_WAIT: begin
                key_held  = 1'b1;
                held_code = cand;
            end
            default: begin
            end
        endcase
    end

    assign key_valid = !fifo_empty;
    assign pop_req   = key_valid && key_ready;

    // Sticky overflow: an accepted press found the queue full and nothing leaving.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop_req) begin
            overflow <= 1'b1;
        end
    end

    keypad_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEYCODE_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_req),
        .push_data (cand),
        .pop       (pop_req),
        .pop_data  (key_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// Expected key codes are queued when a press is issued; a monitor compares
// them against the DUT head on every handshake.
module tb_keypad_debouncer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] keycode;
    logic       keypressed;
    logic       key_valid;
    logic [3:0] key_data;
    logic       key_ready;
    logic       key_held;
    logic [3:0] held_code;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    keypad_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .keycode    (keycode),
        .keypressed (keypressed),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .key_ready  (key_ready),
        .key_held   (key_held),
        .held_code  (held_code),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One press of 9 cycles and release of 9 cycles; long enough for both windows.
    task automatic do_press(input logic [3:0] code, input bit expect_push);
        keycode    = code;
        keypressed = 1'b1;
        if (expect_push) exp_q.push_back(code);
        repeat (9) tick();
        keypressed = 1'b0;
        repeat (9) tick();
    endtask

    // Scoreboard monitor: a pop happens on the next rising edge when valid & ready.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h, no event expected (t=%0t)", key_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_data !== mon_exp) begin
                    errors++;
                    $display("FAIL pop_data: got %0h, expected %0h (t=%0t)", key_data, mon_exp, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        keycode    = 4'h0;
        keypressed = 1'b0;
        key_ready  = 1'b0;
        repeat (3) tick();
        check("rst_valid", key_valid, 0);
        check("rst_data", key_data, 0);
        check("rst_held", key_held, 0);
        check("rst_held_code", held_code, 0);
        check("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Clean press of 7: valid and held rise at edge 7, held falls 7 edges after release.
        key_ready  = 1'b1;
        keycode    = 4'h7;
        keypressed = 1'b1;
        exp_q.push_back(4'h7);
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("t1_held_e%0d", e), key_held, (e == 7));
            check($sformatf("t1_valid_e%0d", e), key_valid, (e == 7));
        end
        check("t1_held_code", held_code, 4'h7);
        repeat (13) tick();
        check("t1_held_stay", key_held, 1);
        check("t1_single_event", key_valid, 0);
        keypressed = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("t1_rel_held_e%0d", e), key_held, (e < 7));
        end
        repeat (3) tick();

        // Bouncing press 1-0-1-0 at 2-cycle intervals, then stable A.
        keycode = 4'hA;
        for (int b = 0; b < 8; b++) begin
            keypressed = ((b / 2) % 2 == 0);
            tick();
            check($sformatf("t2_bounce_held_b%0d", b), key_held, 0);
            check($sformatf("t2_bounce_valid_b%0d", b), key_valid, 0);
        end
        keypressed = 1'b1;
        exp_q.push_back(4'hA);
        repeat (6) tick();
        check("t2_held_e6", key_held, 0);
        tick();
        check("t2_held_e7", key_held, 1);
        keypressed = 1'b0;
        repeat (10) tick();

        // Code 3 changes to 5 after PRESS_WAIT entry: window restarts, event is 5.
        keycode    = 4'h3;
        keypressed = 1'b1;
        exp_q.push_back(4'h5);
        repeat (3) tick();
        keycode = 4'h5;
        repeat (6) tick();
        check("t3_held_e9", key_held, 0);
        tick();
        check("t3_held_e10", key_held, 1);
        check("t3_held_code", held_code, 4'h5);
        keypressed = 1'b0;
        repeat (10) tick();
        check("t3_drained", key_valid, 0);

        // Five presses with no consumer: first four kept, fifth overflows.
        key_ready = 1'b0;
        do_press(4'h1, 1'b1);
        do_press(4'h2, 1'b1);
        do_press(4'h3, 1'b1);
        do_press(4'h4, 1'b1);
        check("t4_overflow_after4", overflow, 0);
        do_press(4'h5, 1'b0);
        check("t4_overflow_after5", overflow, 1);
        check("t4_valid_full", key_valid, 1);
        key_ready = 1'b1;
        repeat (6) tick();
        check("t4_drained", key_valid, 0);
        check("t4_overflow_sticky", overflow, 1);
        key_ready = 1'b0;

        // Fresh reset, fill the queue, then push coinciding with a pop.
        reset_n = 1'b0;
        tick();
        check("t5_overflow_cleared", overflow, 0);
        reset_n = 1'b1;
        tick();
        do_press(4'h9, 1'b1);
        do_press(4'hA, 1'b1);
        do_press(4'hB, 1'b1);
        do_press(4'hC, 1'b1);
        keycode    = 4'hD;
        keypressed = 1'b1;
        exp_q.push_back(4'hD);
        repeat (6) tick();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("t5_overflow", overflow, 0);
        check("t5_held", key_held, 1);
        keypressed = 1'b0;
        repeat (9) tick();
        check("t5_valid", key_valid, 1);
        key_ready = 1'b1;
        repeat (6) tick();
        check("t5_drained", key_valid, 0);
        key_ready = 1'b0;

        // Reset mid-HELD with two entries queued; the held key re-emits after a full window.
        do_press(4'hE, 1'b0);
        keycode    = 4'hF;
        keypressed = 1'b1;
        repeat (9) tick();
        check("t6_pre_held", key_held, 1);
        check("t6_pre_valid", key_valid, 1);
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_async_valid", key_valid, 0);
        check("t6_async_data", key_data, 0);
        check("t6_async_held", key_held, 0);
        check("t6_async_held_code", held_code, 0);
        check("t6_async_overflow", overflow, 0);
        tick();
        reset_n = 1'b1;
        exp_q.push_back(4'hF);
        repeat (6) tick();
        check("t6_held_e6", key_held, 0);
        check("t6_valid_e6", key_valid, 0);
        tick();
        check("t6_held_e7", key_held, 1);
        check("t6_valid_e7", key_valid, 1);
        key_ready = 1'b1;
        repeat (3) tick();
        check("t6_drained", key_valid, 0);
        keypressed = 1'b0;
        repeat (9) tick();

        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
